uart_receiver: RTL



---
 rtl/uart_receiver.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   Serial-to-parallel UART receiver with an internal oversampling tick
//   generator. It finds the start bit, samples each data bit (LSB first) in
//   the middle of its bit period, checks 1 or 2 stop bits, and holds the
//   received byte with a ready flag and sticky framing/overrun flags.
//
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   serial_in      asynchronous serial line, idle high
//   dvsr           tick divisor: one oversampling tick every dvsr+1 clocks
//   stop_2         1 = two stop bits, 0 = one stop bit (latched per frame)
//   read_byte      single-cycle pulse: consumer has taken data_out
//   data_out       last accepted byte
//   byte_ready     data_out holds an unread byte
//   framing_error  sticky: a stop bit was sampled low
//   overrun_error  sticky: a byte arrived while byte_ready was set
//   bit_cnt_out    data bits received in the current frame, 0 when idle
//
// Handshake: byte_ready rises one clock after the final stop-bit sample.
// A read_byte pulse while byte_ready=1 clears byte_ready and both error
// flags on the next clock; while byte_ready=0 it is ignored. If read_byte
// lands in the same cycle a frame completes, the new byte is delivered and
// the flags reflect only that new frame.
// ---------------------------------------------------------------------------
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic [31:0]          dvsr,
  input  logic                 stop_2,
  input  logic                 read_byte,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 byte_ready,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic [3:0]           bit_cnt_out
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_END    = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    BIT_LAST = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP1 = 3'd3,
    STOP2 = 3'd4
  } state_e;

  // Synchronizer and tick generator
  logic                 sync1_q, rx_q;
  logic [31:0]          t_cnt_q, t_cnt_d;
  logic                 tick;

  // Frame FSM
  state_e               state_q, state_d;
  logic [SW-1:0]        s_cnt_q, s_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 stop2_q, stop2_d;
  logic                 stop_err_q, stop_err_d;
  logic                 done;
  logic                 frame_err;

  // Holding register and flags
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 fe_q, fe_d;
  logic                 oe_q, oe_d;
  logic                 clr;

  // Wrap on >= rather than == so that lowering dvsr below the current count
  // only disturbs the frame in flight instead of running the counter to 2^32.
  always_comb begin
    tick    = (t_cnt_q == dvsr);
    t_cnt_d = (t_cnt_q >= dvsr) ? 32'd0 : t_cnt_q + 32'd1;
  end

  always_comb begin
    state_d    = state_q;
    s_cnt_d    = s_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    stop2_d    = stop2_q;
    stop_err_d = stop_err_q;
    done       = 1'b0;
    frame_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick && !rx_q) begin
          state_d    = START;
          s_cnt_d    = '0;
          stop2_d    = stop_2;
          stop_err_d = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (s_cnt_q == S_MID) begin
            s_cnt_d = '0;
            if (!rx_q) begin
              state_d   = DATA;
              bit_cnt_d = 4'd0;
            end else begin
              state_d = IDLE;  // too short to be a start bit
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_cnt_q == S_END) begin
            s_cnt_d   = '0;
            shreg_d   = {rx_q, shreg_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == BIT_LAST) state_d = STOP1;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      STOP1: begin
        if (tick) begin
          if (s_cnt_q == S_END) begin
            s_cnt_d = '0;
            if (stop2_q) begin
              stop_err_d = !rx_q;
              state_d    = STOP2;
            end else begin
              frame_err = !rx_q;
              done      = 1'b1;
              state_d   = IDLE;
              bit_cnt_d = 4'd0;
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      STOP2: begin
        if (tick) begin
          if (s_cnt_q == S_END) begin
            s_cnt_d   = '0;
            frame_err = stop_err_q | !rx_q;
            done      = 1'b1;
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A read accepted in the completion cycle makes the old flags irrelevant,
  // so the new frame's status replaces them instead of accumulating.
  always_comb begin
    data_d  = data_q;
    ready_d = ready_q;
    fe_d    = fe_q;
    oe_d    = oe_q;
    clr     = read_byte && ready_q;
    if (done) begin
      fe_d = clr ? frame_err : (fe_q | frame_err);
      if (!ready_q || read_byte) begin
        data_d  = shreg_q;
        ready_d = 1'b1;
        oe_d    = clr ? 1'b0 : oe_q;
      end else begin
        oe_d = 1'b1;  // new byte dropped, unread byte kept
      end
    end else if (clr) begin
      ready_d = 1'b0;
      fe_d    = 1'b0;
      oe_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rx_q       <= 1'b1;
      t_cnt_q    <= '0;
      state_q    <= IDLE;
      s_cnt_q    <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      stop2_q    <= 1'b0;
      stop_err_q <= 1'b0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      fe_q       <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      sync1_q    <= serial_in;
      rx_q       <= sync1_q;
      t_cnt_q    <= t_cnt_d;
      state_q    <= state_d;
      s_cnt_q    <= s_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      stop2_q    <= stop2_d;
      stop_err_q <= stop_err_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      fe_q       <= fe_d;
      oe_q       <= oe_d;
    end
  end

  assign data_out      = data_q;
  assign byte_ready    = ready_q;
  assign framing_error = fe_q;
  assign overrun_error = oe_q;
  assign bit_cnt_out   = bit_cnt_q;

endmodule
